// File: rtl/assoc_tag_fifo_pkg.sv
// Shared constants for the tagged FIFO with associative lookup cache.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
package assoc_tag_fifo_pkg;

   localparam int REPL_FIFO = 0;
   localparam int REPL_LRU  = 1;
   localparam int REPL_RAND = 2;

   // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> state bits 15,13,12,10
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Ceiling log2 for elaboration-time widths
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/cache_repl_ctrl.sv
// Replacement state for the lookup cache: LRU ages, round-robin pointer, LFSR.
// Latency: victim_way is combinational from current state; updates take effect next cycle.
// Backpressure: none; touch/fill strobes are accepted every cycle.
module cache_repl_ctrl
   import assoc_tag_fifo_pkg::*;
#(
   parameter int NUM_WAYS  = 4,
   parameter int REPL_MODE = REPL_LRU,
   localparam int WW       = clog2(NUM_WAYS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_touch,
   input  logic [WW-1:0]       i_touch_way,
   input  logic                i_fill,
   input  logic                i_flush,
   input  logic [NUM_WAYS-1:0] i_way_vld,
   output logic [WW-1:0]       o_victim_way
);

   logic [WW-1:0] r_age [NUM_WAYS];
   logic [WW-1:0] r_rr_ptr;
   logic [15:0]   r_lfsr;
   logic [WW-1:0] w_lru_way;
   logic [WW-1:0] w_free_way;
   logic          w_free_found;
   logic [WW-1:0] w_full_way;

   // Touched way becomes youngest; ways younger than its old age slide down by one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_WAYS; i++) r_age[i] <= WW'(i);
      end else if (i_flush) begin
         for (int i = 0; i < NUM_WAYS; i++) r_age[i] <= WW'(i);
      end else if (i_touch) begin
         for (int i = 0; i < NUM_WAYS; i++) begin
            if (WW'(i) == i_touch_way)
               r_age[i] <= WW'(NUM_WAYS - 1);
            else if (r_age[i] > r_age[i_touch_way])
               r_age[i] <= r_age[i] - WW'(1);
         end
      end
   end

   // Round-robin pointer advances per fill; LFSR free-runs every cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr <= '0;
         r_lfsr   <= LFSR_SEED;
      end else begin
         r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
         if (i_flush)
            r_rr_ptr <= '0;
         else if (i_fill)
            r_rr_ptr <= r_rr_ptr + WW'(1);
      end
   end

   // Victim: lowest invalid way first, otherwise the mode-specific choice
   always_comb begin
      w_lru_way    = '0;
      w_free_way   = '0;
      w_free_found = 1'b0;
      for (int i = 0; i < NUM_WAYS; i++)
         if (r_age[i] == '0) w_lru_way = WW'(i);
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
         if (!i_way_vld[i]) begin
            w_free_found = 1'b1;
            w_free_way   = WW'(i);
         end
      end
      case (REPL_MODE)
         REPL_FIFO: w_full_way = r_rr_ptr;
         REPL_RAND: w_full_way = r_lfsr[WW-1:0];
         default:   w_full_way = w_lru_way;
      endcase
      o_victim_way = w_free_found ? w_free_way : w_full_way;
   end

endmodule

// File: rtl/assoc_tag_fifo.sv
// Tagged FIFO with a fully-associative lookup cache, in-order dequeue and statistics.
// Latency: lookup and pop responses are registered, 1 cycle after the request.
// Backpressure: wr_ready = !full; lookups and pops are never stalled.
module assoc_tag_fifo
   import assoc_tag_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int TAG_WIDTH  = 8,
   parameter int NUM_WAYS   = 4,
   parameter int REPL_MODE  = REPL_LRU,
   parameter int STAT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [TAG_WIDTH-1:0]  wr_tag,
   output logic                  wr_ready,
   input  logic                  pop_en,
   output logic                  pop_valid,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic [TAG_WIDTH-1:0]  pop_tag,
   input  logic                  lk_valid,
   input  logic [TAG_WIDTH-1:0]  lk_tag,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_hit,
   output logic                  rsp_found,
   input  logic                  flush,
   input  logic                  clear_stats,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   data_count,
   output logic [STAT_WIDTH-1:0] hit_count,
   output logic [STAT_WIDTH-1:0] miss_count,
   output logic [STAT_WIDTH-1:0] nf_count
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int WW    = clog2(NUM_WAYS);

   logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
   logic [TAG_WIDTH-1:0]  r_mem_tag  [DEPTH];
   logic [DEPTH-1:0]      r_slot_vld;
   logic [ADDR_WIDTH:0]   r_wr_ptr, r_rd_ptr;
   logic [NUM_WAYS-1:0]   r_way_vld;
   logic [TAG_WIDTH-1:0]  r_way_tag  [NUM_WAYS];
   logic [DATA_WIDTH-1:0] r_way_data [NUM_WAYS];
   logic                  r_rsp_valid, r_rsp_hit, r_rsp_found, r_pop_valid;
   logic [DATA_WIDTH-1:0] r_rsp_data, r_pop_data;
   logic [TAG_WIDTH-1:0]  r_pop_tag;
   logic [STAT_WIDTH-1:0] r_hit_cnt, r_miss_cnt, r_nf_cnt;

   logic [ADDR_WIDTH:0]   w_count;
   logic                  w_full, w_empty, w_push, w_pop;
   logic                  w_hit, w_fifo_found, w_fill, w_touch;
   logic [WW-1:0]         w_hit_way, w_victim;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic [DATA_WIDTH-1:0] w_fifo_data, w_rsp_data;

   assign w_count    = r_wr_ptr - r_rd_ptr;
   assign w_full     = (w_count == (ADDR_WIDTH+1)'(DEPTH));
   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_push     = wr_valid && !w_full;
   assign w_pop      = pop_en && !w_empty;
   assign w_fill     = lk_valid && !w_hit && w_fifo_found && !flush;
   assign w_touch    = lk_valid && (w_hit || w_fifo_found) && !flush;
   assign w_rsp_data = w_hit ? r_way_data[w_hit_way] : (w_fifo_found ? w_fifo_data : '0);

   // Cache tag compare; tags are unique across valid ways so the first match suffices
   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = '0;
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
         if (r_way_vld[i] && r_way_tag[i] == lk_tag) begin
            w_hit     = 1'b1;
            w_hit_way = WW'(i);
         end
      end
   end

   // FIFO search from head to tail so the youngest matching slot wins
   always_comb begin
      w_fifo_found = 1'b0;
      w_fifo_data  = '0;
      w_idx        = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_rd_ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(k);
         if (r_slot_vld[w_idx] && r_mem_tag[w_idx] == lk_tag) begin
            w_fifo_found = 1'b1;
            w_fifo_data  = r_mem_data[w_idx];
         end
      end
   end

   // FIFO payload storage needs no reset; occupancy is tracked by valid bits
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
         r_mem_tag[r_wr_ptr[ADDR_WIDTH-1:0]]  <= wr_tag;
      end
   end

   // Pointers, slot valid bits and the registered pop response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_slot_vld  <= '0;
         r_pop_valid <= 1'b0;
         r_pop_data  <= '0;
         r_pop_tag   <= '0;
      end else begin
         r_pop_valid <= w_pop;
         if (w_push) begin
            r_slot_vld[r_wr_ptr[ADDR_WIDTH-1:0]] <= 1'b1;
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_slot_vld[r_rd_ptr[ADDR_WIDTH-1:0]] <= 1'b0;
            r_pop_data <= r_mem_data[r_rd_ptr[ADDR_WIDTH-1:0]];
            r_pop_tag  <= r_mem_tag[r_rd_ptr[ADDR_WIDTH-1:0]];
            r_rd_ptr   <= r_rd_ptr + 1'b1;
         end
      end
   end

   // Cache ways: push write-update, then miss fill (push data wins on same tag), flush last
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_way_vld <= '0;
         for (int i = 0; i < NUM_WAYS; i++) begin
            r_way_tag[i]  <= '0;
            r_way_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_WAYS; i++)
            if (w_push && r_way_vld[i] && r_way_tag[i] == wr_tag) r_way_data[i] <= wr_data;
         if (w_fill) begin
            r_way_vld[w_victim]  <= 1'b1;
            r_way_tag[w_victim]  <= lk_tag;
            r_way_data[w_victim] <= (w_push && wr_tag == lk_tag) ? wr_data : w_fifo_data;
         end
         if (flush) r_way_vld <= '0;
      end
   end

   // Registered lookup response reflecting pre-update state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_valid <= 1'b0;
         r_rsp_hit   <= 1'b0;
         r_rsp_found <= 1'b0;
         r_rsp_data  <= '0;
      end else begin
         r_rsp_valid <= lk_valid;
         r_rsp_hit   <= lk_valid && w_hit;
         r_rsp_found <= lk_valid && (w_hit || w_fifo_found);
         r_rsp_data  <= lk_valid ? w_rsp_data : '0;
      end
   end

   // Saturating statistics; clear beats a same-cycle increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
         r_nf_cnt   <= '0;
      end else if (clear_stats) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
         r_nf_cnt   <= '0;
      end else if (lk_valid) begin
         if (w_hit && r_hit_cnt != '1)
            r_hit_cnt <= r_hit_cnt + STAT_WIDTH'(1);
         if (!w_hit && w_fifo_found && r_miss_cnt != '1)
            r_miss_cnt <= r_miss_cnt + STAT_WIDTH'(1);
         if (!w_hit && !w_fifo_found && r_nf_cnt != '1)
            r_nf_cnt <= r_nf_cnt + STAT_WIDTH'(1);
      end
   end

   cache_repl_ctrl #(
      .NUM_WAYS  (NUM_WAYS),
      .REPL_MODE (REPL_MODE)
   ) u_repl (
      .clk          (clk),
      .rst          (rst),
      .i_touch      (w_touch),
      .i_touch_way  (w_hit ? w_hit_way : w_victim),
      .i_fill       (w_fill),
      .i_flush      (flush),
      .i_way_vld    (r_way_vld),
      .o_victim_way (w_victim)
   );

   assign wr_ready   = !w_full;
   assign full       = w_full;
   assign empty      = w_empty;
   assign data_count = w_count;
   assign pop_valid  = r_pop_valid;
   assign pop_data   = r_pop_data;
   assign pop_tag    = r_pop_tag;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_data   = r_rsp_data;
   assign rsp_hit    = r_rsp_hit;
   assign rsp_found  = r_rsp_found;
   assign hit_count  = r_hit_cnt;
   assign miss_count = r_miss_cnt;
   assign nf_count   = r_nf_cnt;

endmodule

// File: tb/tb_assoc_tag_fifo.sv
// Directed bench for assoc_tag_fifo with default parameters (16 deep, 4-way LRU).
// Latency: responses sampled 1 ns after the edge that registers them.
// Backpressure: exercises full-FIFO push rejection.
module tb_assoc_tag_fifo;

   logic        clk, rst;
   logic        wr_valid, wr_ready, pop_en, pop_valid, lk_valid;
   logic        rsp_valid, rsp_hit, rsp_found, flush, clear_stats, full, empty;
   logic [31:0] wr_data, pop_data, rsp_data, hit_count, miss_count, nf_count;
   logic [7:0]  wr_tag, pop_tag, lk_tag;
   logic [4:0]  data_count;
   int          total, bad;

   assoc_tag_fifo dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_tag(wr_tag), .wr_ready(wr_ready),
      .pop_en(pop_en), .pop_valid(pop_valid), .pop_data(pop_data), .pop_tag(pop_tag),
      .lk_valid(lk_valid), .lk_tag(lk_tag),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit), .rsp_found(rsp_found),
      .flush(flush), .clear_stats(clear_stats),
      .full(full), .empty(empty), .data_count(data_count),
      .hit_count(hit_count), .miss_count(miss_count), .nf_count(nf_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      wr_valid = 0; wr_data = 0; wr_tag = 0; pop_en = 0; lk_valid = 0; lk_tag = 0;
      flush = 0; clear_stats = 0;
      rst = 1;
      cyc();
      cyc();
      rst = 0;
   endtask

   task automatic push(input logic [7:0] t, input logic [31:0] d);
      wr_valid = 1; wr_tag = t; wr_data = d;
      cyc();
      wr_valid = 0;
   endtask

   task automatic lookup(input logic [7:0] t);
      lk_valid = 1; lk_tag = t;
      cyc();
      lk_valid = 0;
   endtask

   task automatic pop();
      pop_en = 1;
      cyc();
      pop_en = 0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({rsp_valid, rsp_hit, rsp_found, pop_valid, full, empty, wr_ready} !== 7'b0000011) begin
         bad++;
         $display("FAIL reset_flags got=%b want=0000011",
                  {rsp_valid, rsp_hit, rsp_found, pop_valid, full, empty, wr_ready});
      end
      total++;
      if (data_count !== 5'd0 || rsp_data !== 32'd0 || pop_data !== 32'd0) begin
         bad++;
         $display("FAIL reset_data got count=%0d rsp=%0h pop=%0h want 0", data_count, rsp_data, pop_data);
      end
      total++;
      if (hit_count !== 0 || miss_count !== 0 || nf_count !== 0) begin
         bad++;
         $display("FAIL reset_stats got=%0d/%0d/%0d want=0/0/0", hit_count, miss_count, nf_count);
      end
   endtask

   task automatic test_fill_full();
      do_reset();
      for (int i = 1; i <= 16; i++) push(8'(i), 32'(i * 3));
      total++;
      if (full !== 1'b1 || wr_ready !== 1'b0 || data_count !== 5'd16) begin
         bad++;
         $display("FAIL full_flags got full=%b rdy=%b count=%0d want 1 0 16", full, wr_ready, data_count);
      end
      push(8'd17, 32'd51);
      total++;
      if (data_count !== 5'd16) begin
         bad++;
         $display("FAIL push_when_full got=%0d want=16", data_count);
      end
      lookup(8'd17);
      total++;
      if (rsp_valid !== 1'b1 || rsp_found !== 1'b0) begin
         bad++;
         $display("FAIL tag17_absent got valid=%b found=%b want 1 0", rsp_valid, rsp_found);
      end
      // push rejected while full even though a pop happens in the same cycle
      wr_valid = 1; wr_tag = 8'd17; wr_data = 32'd51; pop_en = 1;
      cyc();
      wr_valid = 0; pop_en = 0;
      total++;
      if (data_count !== 5'd15 || pop_valid !== 1'b1 || pop_tag !== 8'd1 || pop_data !== 32'd3) begin
         bad++;
         $display("FAIL full_push_pop got count=%0d pv=%b tag=%0d data=%0d want 15 1 1 3",
                  data_count, pop_valid, pop_tag, pop_data);
      end
      for (int i = 2; i <= 16; i++) begin
         pop();
         total++;
         if (pop_valid !== 1'b1 || pop_tag !== 8'(i) || pop_data !== 32'(i * 3)) begin
            bad++;
            $display("FAIL drain_%0d got pv=%b tag=%0d data=%0d want 1 %0d %0d",
                     i, pop_valid, pop_tag, pop_data, i, i * 3);
         end
      end
      total++;
      if (empty !== 1'b1) begin
         bad++;
         $display("FAIL drain_empty got=%b want=1", empty);
      end
   endtask

   task automatic test_lru();
      logic [7:0] seq [7];
      logic       exp_hit [7];
      seq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd5, 8'd2};
      exp_hit = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      do_reset();
      for (int i = 1; i <= 5; i++) push(8'(i), 32'(i * 3));
      for (int i = 0; i < 7; i++) begin
         lookup(seq[i]);
         total++;
         if (rsp_hit !== exp_hit[i] || rsp_found !== 1'b1 || rsp_data !== 32'(seq[i]) * 3) begin
            bad++;
            $display("FAIL lru_step%0d got hit=%b found=%b data=%0d want %b 1 %0d",
                     i, rsp_hit, rsp_found, rsp_data, exp_hit[i], seq[i] * 3);
         end
      end
      total++;
      if (hit_count !== 32'd1 || miss_count !== 32'd6) begin
         bad++;
         $display("FAIL lru_stats got hit=%0d miss=%0d want 1 6", hit_count, miss_count);
      end
   endtask

   task automatic test_write_update();
      do_reset();
      push(8'd7, 32'hA);
      push(8'd7, 32'hB);
      lookup(8'd7);
      total++;
      if (rsp_found !== 1'b1 || rsp_hit !== 1'b0 || rsp_data !== 32'hB) begin
         bad++;
         $display("FAIL youngest_wins got found=%b hit=%b data=%0h want 1 0 b", rsp_found, rsp_hit, rsp_data);
      end
      push(8'd7, 32'hC);
      lookup(8'd7);
      total++;
      if (rsp_hit !== 1'b1 || rsp_data !== 32'hC) begin
         bad++;
         $display("FAIL write_update got hit=%b data=%0h want 1 c", rsp_hit, rsp_data);
      end
      wr_valid = 1; wr_tag = 8'd7; wr_data = 32'hD; lk_valid = 1; lk_tag = 8'd7;
      cyc();
      wr_valid = 0; lk_valid = 0;
      total++;
      if (rsp_hit !== 1'b1 || rsp_data !== 32'hC) begin
         bad++;
         $display("FAIL same_cycle_prepush got hit=%b data=%0h want 1 c", rsp_hit, rsp_data);
      end
      lookup(8'd7);
      total++;
      if (rsp_hit !== 1'b1 || rsp_data !== 32'hD) begin
         bad++;
         $display("FAIL same_cycle_write_wins got hit=%b data=%0h want 1 d", rsp_hit, rsp_data);
      end
   endtask

   task automatic test_not_found();
      do_reset();
      push(8'd1, 32'd3);
      lookup(8'd1);
      lookup(8'h55);
      total++;
      if (rsp_valid !== 1'b1 || rsp_found !== 1'b0 || rsp_hit !== 1'b0 || rsp_data !== 32'd0) begin
         bad++;
         $display("FAIL not_found got v=%b found=%b hit=%b data=%0h want 1 0 0 0",
                  rsp_valid, rsp_found, rsp_hit, rsp_data);
      end
      total++;
      if (nf_count !== 32'd1 || miss_count !== 32'd1) begin
         bad++;
         $display("FAIL nf_stats got nf=%0d miss=%0d want 1 1", nf_count, miss_count);
      end
      lookup(8'd1);
      total++;
      if (rsp_hit !== 1'b1 || rsp_data !== 32'd3) begin
         bad++;
         $display("FAIL cache_kept got hit=%b data=%0d want 1 3", rsp_hit, rsp_data);
      end
   endtask

   task automatic test_pop_order();
      do_reset();
      for (int i = 0; i < 4; i++) push(8'(8'h10 + i), 32'(32'h100 + i));
      for (int i = 0; i < 4; i++) begin
         pop();
         total++;
         if (pop_valid !== 1'b1 || pop_tag !== 8'(8'h10 + i) || pop_data !== 32'(32'h100 + i)) begin
            bad++;
            $display("FAIL pop_order%0d got pv=%b tag=%0h data=%0h want 1 %0h %0h",
                     i, pop_valid, pop_tag, pop_data, 8'h10 + i, 32'h100 + i);
         end
      end
      pop();
      total++;
      if (pop_valid !== 1'b0 || empty !== 1'b1) begin
         bad++;
         $display("FAIL pop_empty got pv=%b empty=%b want 0 1", pop_valid, empty);
      end
      for (int i = 0; i < 40; i++) begin
         push(8'(i), 32'(i) ^ 32'h5A5A);
         pop();
         total++;
         if (data_count !== 5'd0 || pop_tag !== 8'(i) || pop_data !== (32'(i) ^ 32'h5A5A)) begin
            bad++;
            $display("FAIL wrap%0d got count=%0d tag=%0h data=%0h want 0 %0h %0h",
                     i, data_count, pop_tag, pop_data, i, 32'(i) ^ 32'h5A5A);
         end
      end
      push(8'h20, 32'h77);
      pop_en = 1; lk_valid = 1; lk_tag = 8'h20;
      cyc();
      pop_en = 0; lk_valid = 0;
      total++;
      if (rsp_found !== 1'b1 || rsp_data !== 32'h77 || pop_valid !== 1'b1) begin
         bad++;
         $display("FAIL head_searchable got found=%b data=%0h pv=%b want 1 77 1", rsp_found, rsp_data, pop_valid);
      end
   endtask

   task automatic test_flush();
      do_reset();
      push(8'd9, 32'h99);
      lookup(8'd9);
      flush = 1; lk_valid = 1; lk_tag = 8'd9;
      cyc();
      flush = 0; lk_valid = 0;
      total++;
      if (rsp_hit !== 1'b1 || rsp_data !== 32'h99) begin
         bad++;
         $display("FAIL flush_prestate got hit=%b data=%0h want 1 99", rsp_hit, rsp_data);
      end
      lookup(8'd9);
      total++;
      if (rsp_hit !== 1'b0 || rsp_found !== 1'b1) begin
         bad++;
         $display("FAIL after_flush got hit=%b found=%b want 0 1", rsp_hit, rsp_found);
      end
      total++;
      if (hit_count !== 32'd1 || miss_count !== 32'd2) begin
         bad++;
         $display("FAIL flush_stats got hit=%0d miss=%0d want 1 2", hit_count, miss_count);
      end
      clear_stats = 1; lk_valid = 1; lk_tag = 8'd9;
      cyc();
      clear_stats = 0; lk_valid = 0;
      total++;
      if (rsp_hit !== 1'b1 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
         bad++;
         $display("FAIL clear_priority got hit=%b hc=%0d mc=%0d want 1 0 0", rsp_hit, hit_count, miss_count);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      push(8'd3, 32'h33);
      lk_valid = 1; lk_tag = 8'd3; pop_en = 1;
      cyc();
      pop_en = 0;
      total++;
      if (rsp_valid !== 1'b1 || pop_valid !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset got rv=%b pv=%b want 1 1", rsp_valid, pop_valid);
      end
      #3 rst = 1;
      #1;
      total++;
      if (rsp_valid !== 1'b0 || pop_valid !== 1'b0) begin
         bad++;
         $display("FAIL async_reset got rv=%b pv=%b want 0 0", rsp_valid, pop_valid);
      end
      cyc();
      total++;
      if (rsp_valid !== 1'b0 || empty !== 1'b1) begin
         bad++;
         $display("FAIL reset_edge got rv=%b empty=%b want 0 1", rsp_valid, empty);
      end
      rst = 0; lk_valid = 0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_fill_full();
      test_lru();
      test_write_update();
      test_not_found();
      test_pop_order();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
